// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and helpers for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned PC_STEP     = 2;
    localparam int unsigned COUNT_WIDTH = 16;
    localparam logic [15:0] HALT_WORD   = 16'h0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
        return (value == '1) ? value : value + COUNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush (zero bubble) > load > drop (clear valid, keep data) > hold.
module if_id_reg #(
    parameter int unsigned PC_WIDTH    = 16,
    parameter int unsigned INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   flush,
    input  logic                   drop,
    input  logic [INSTR_WIDTH-1:0] fetched_instr,
    input  logic [PC_WIDTH-1:0]    fetched_pc,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0]    if_id_pc,
    output logic                   if_id_valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
        end else if (flush) begin
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
        end else if (load) begin
            if_id_instr <= fetched_instr;
            if_id_pc    <= fetched_pc;
            if_id_valid <= 1'b1;
        end else if (drop) begin
            if_id_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, next-PC select, RUN/HALT control and delivered-instruction counter.
// Optional halt on the all-zero word is enabled by defining FETCH_HALT_ON_ZERO_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned          PC_WIDTH    = 16,
    parameter int unsigned          INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic [PC_WIDTH-1:0]    pc,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0]    if_id_pc,
    output logic                   if_id_valid,
    output logic [COUNT_WIDTH-1:0] fetch_count,
    output logic                   halted
);

    fetch_state_t state;
    logic         halt_hit;
    logic         load;
    logic         flush;
    logic         drop;
    logic         halt_go;

`ifdef FETCH_HALT_ON_ZERO_EN
    assign halt_hit = (instr_in == INSTR_WIDTH'(HALT_WORD));
`else
    assign halt_hit = 1'b0;
`endif

    // Per-edge action: halt freeze, then redirect > stall > halt word > advance.
    always_comb begin
        load    = 1'b0;
        flush   = 1'b0;
        drop    = 1'b0;
        halt_go = 1'b0;
        if (state == HALT) begin
            drop = 1'b1;
        end else if (redirect_valid) begin
            flush = 1'b1;
        end else if (!stall) begin
            if (halt_hit) begin
                drop    = 1'b1;
                halt_go = 1'b1;
            end else begin
                load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            fetch_count <= '0;
            halted      <= 1'b0;
        end else begin
            if (flush) begin
                pc <= redirect_pc & ~PC_WIDTH'(1);
            end else if (load) begin
                pc          <= pc + PC_WIDTH'(PC_STEP);
                fetch_count <= sat_inc(fetch_count);
            end
            if (halt_go) begin
                state  <= HALT;
                halted <= 1'b1;
            end
        end
    end

    if_id_reg #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_if_id_reg (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .flush         (flush),
        .drop          (drop),
        .fetched_instr (instr_in),
        .fetched_pc    (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_stage;

`ifdef FETCH_HALT_ON_ZERO_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] pc;
    logic [15:0] instr_in;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic [15:0] fetch_count;
    logic        halted;

    logic [15:0] rom [16];
    int          checks = 0;
    int          errors = 0;
    bit          cmp_en = 1'b0;

    // Behavioural model state
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;
    logic        m_valid;
    logic        m_halted;
    int          m_count;

    always #5 clk = ~clk;

    assign instr_in = rom[pc[4:1]];

    fetch_stage #(
        .PC_WIDTH    (16),
        .INSTR_WIDTH (16),
        .RESET_PC    (16'h0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .instr_in       (instr_in),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_valid    (if_id_valid),
        .fetch_count    (fetch_count),
        .halted         (halted)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: the fetch rules applied to the word the ROM holds at the model's own PC.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc     <= 16'h0000;
            m_instr  <= 16'h0000;
            m_ipc    <= 16'h0000;
            m_valid  <= 1'b0;
            m_halted <= 1'b0;
            m_count  <= 0;
        end else if (m_halted) begin
            m_valid <= 1'b0;
        end else if (redirect_valid) begin
            m_pc    <= 16'((int'(redirect_pc) / 2) * 2);
            m_instr <= 16'h0000;
            m_ipc   <= 16'h0000;
            m_valid <= 1'b0;
        end else if (!stall) begin
            if (HALT_EN && rom[m_pc[4:1]] == 16'h0000) begin
                m_valid  <= 1'b0;
                m_halted <= 1'b1;
            end else begin
                m_instr <= rom[m_pc[4:1]];
                m_ipc   <= m_pc;
                m_valid <= 1'b1;
                m_pc    <= 16'((int'(m_pc) + 2) % 65536);
                m_count <= (m_count < 65535) ? m_count + 1 : 65535;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("pc", 32'(pc), 32'(m_pc));
            check("if_id_instr", 32'(if_id_instr), 32'(m_instr));
            check("if_id_pc", 32'(if_id_pc), 32'(m_ipc));
            check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
            check("fetch_count", 32'(fetch_count), 32'(m_count));
            check("halted", 32'(halted), 32'(m_halted));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_reset_values(input string tag);
        check({tag, "_pc"}, 32'(pc), 32'h0000);
        check({tag, "_instr"}, 32'(if_id_instr), 32'h0000);
        check({tag, "_ipc"}, 32'(if_id_pc), 32'h0000);
        check({tag, "_valid"}, 32'(if_id_valid), 32'h0);
        check({tag, "_count"}, 32'(fetch_count), 32'h0000);
        check({tag, "_halted"}, 32'(halted), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 16'hA000 | 16'(i);
        rom[0] = 16'h8080;
        rom[1] = 16'h8101;
        rom[2] = 16'h0000;
        #1 reset = 1'b1;
        step();
        step();
        cmp_en = 1'b1;
        expect_reset_values("reset");
        reset = 1'b0;

        step();
        check("e1_instr", 32'(if_id_instr), 32'h8080);
        check("e1_ipc", 32'(if_id_pc), 32'h0000);
        check("e1_valid", 32'(if_id_valid), 32'h1);
        check("e1_pc", 32'(pc), 32'h0002);
        step();
        check("e2_instr", 32'(if_id_instr), 32'h8101);
        check("e2_count", 32'(fetch_count), 32'd2);
        check("e2_pc", 32'(pc), 32'h0004);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", 32'(pc), 32'h0004);
            check("stall_instr", 32'(if_id_instr), 32'h8101);
            check("stall_count", 32'(fetch_count), 32'd2);
        end
        stall = 1'b0;
        step();
`ifdef FETCH_HALT_ON_ZERO_EN
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_pc", 32'(pc), 32'h0004);
        check("halt_valid", 32'(if_id_valid), 32'h0);
        check("halt_count", 32'(fetch_count), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0020;
        step();
        redirect_valid = 1'b0;
        check("halt_redirect_pc", 32'(pc), 32'h0004);
        check("halt_redirect_halted", 32'(halted), 32'h1);
`else
        check("zero_pc", 32'(pc), 32'h0006);
        check("zero_instr", 32'(if_id_instr), 32'h0000);
        check("zero_valid", 32'(if_id_valid), 32'h1);
        check("zero_halted", 32'(halted), 32'h0);
        check("zero_count", 32'(fetch_count), 32'd3);
        step();
        check("pre_redirect_pc", 32'(pc), 32'h0008);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0013;
        stall = 1'b1;
        step();
        redirect_valid = 1'b0;
        stall = 1'b0;
        check("redirect_pc", 32'(pc), 32'h0012);
        check("redirect_bubble", 32'(if_id_valid), 32'h0);
        step();
        check("target_instr", 32'(if_id_instr), 32'hA009);
        check("target_valid", 32'(if_id_valid), 32'h1);
        check("target_ipc", 32'(if_id_pc), 32'h0012);
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFF;
        step();
        redirect_valid = 1'b0;
        check("wrap_setup_pc", 32'(pc), 32'hFFFE);
        step();
        check("wrap_pc", 32'(pc), 32'h0000);
        check("wrap_ipc", 32'(if_id_pc), 32'hFFFE);
        check("wrap_instr", 32'(if_id_instr), 32'hA00F);
`endif

        // Asynchronous reset between edges must clear everything without a clock edge.
        #2 reset = 1'b1;
        #1 expect_reset_values("async");
        step();
        reset = 1'b0;

        // Randomized traffic with occasional mid-cycle resets to leave any halt.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc % 200 == 199) begin
                #2 reset = 1'b1;
                for (int i = 0; i < 16; i++)
                    rom[i] = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
                step();
                reset = 1'b0;
            end
            stall = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc = 16'($urandom);
            step();
        end
        stall = 1'b0;
        redirect_valid = 1'b0;

        // Long uninterrupted run to drive the counter into saturation.
        #2 reset = 1'b1;
        for (int i = 0; i < 16; i++) rom[i] = 16'h5000 | 16'(i);
        step();
        reset = 1'b0;
        for (int i = 0; i < 65540; i++) step();
        check("count_saturated", 32'(fetch_count), 32'h0000FFFF);
        check("count_valid", 32'(if_id_valid), 32'h1);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
